// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller.
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Shadow entry layout: {wen, load, waddr[aw-1:0]}
    function automatic int unsigned entry_w(input int unsigned aw);
        return aw + 2;
    endfunction

    // Nearest producer wins: EXE-stage result is younger than MEM-stage result.
    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
        if (ex_hit) begin
            return FWD_EXMEM;
        end else if (mem_hit) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Source-register vs. shadow-entry match; r0 never matches.
module hazard_cmp #(
    parameter int unsigned AW = 5
) (
    input  logic          used,
    input  logic [AW-1:0] src,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    output logic          hit
);

    assign hit = used && (src != '0) && wen && (waddr == src);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for a 5-stage pipeline.
// Define PIPE_FWD_EN to enable operand forwarding; otherwise dependants stall.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned AW          = 5,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned INIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             id_wen,
    input  logic [AW-1:0]    id_waddr,
    input  logic             id_is_load,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             bubble_idexe,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             busy_init
);

    localparam int unsigned EW = entry_w(AW);
    localparam int unsigned IW = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES + 1);

    logic [EW-1:0]    ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [0:0]       state_q, state_d;
    logic [IW-1:0]    init_cnt_q, init_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic in_init, haz, stall;
    logic rs1_ex_hit, rs2_ex_hit, rs1_mem_hit, rs2_mem_hit;
    logic unused_wb;

    hazard_cmp #(.AW(AW)) u_cmp_rs1_ex (
        .used  (id_rs1_used),
        .src   (id_rs1),
        .wen   (ex_q[EW-1]),
        .waddr (ex_q[AW-1:0]),
        .hit   (rs1_ex_hit)
    );

    hazard_cmp #(.AW(AW)) u_cmp_rs2_ex (
        .used  (id_rs2_used),
        .src   (id_rs2),
        .wen   (ex_q[EW-1]),
        .waddr (ex_q[AW-1:0]),
        .hit   (rs2_ex_hit)
    );

    hazard_cmp #(.AW(AW)) u_cmp_rs1_mem (
        .used  (id_rs1_used),
        .src   (id_rs1),
        .wen   (mem_q[EW-1]),
        .waddr (mem_q[AW-1:0]),
        .hit   (rs1_mem_hit)
    );

    hazard_cmp #(.AW(AW)) u_cmp_rs2_mem (
        .used  (id_rs2_used),
        .src   (id_rs2),
        .wen   (mem_q[EW-1]),
        .waddr (mem_q[AW-1:0]),
        .hit   (rs2_mem_hit)
    );

    always_comb begin
        in_init = (state_q == ST_INIT);
`ifdef PIPE_FWD_EN
        // Only load-use needs a stall; everything else is forwarded.
        haz = id_valid && ex_q[EW-2] && (rs1_ex_hit || rs2_ex_hit);
`else
        haz = id_valid && (rs1_ex_hit || rs2_ex_hit || rs1_mem_hit || rs2_mem_hit);
`endif
        stall = in_init || haz;
    end

    assign stall_pc     = stall;
    assign stall_ifid   = stall;
    assign bubble_idexe = stall;
    assign busy_init    = in_init;
    assign stall_cnt    = stall_cnt_q;

    // WB producers are covered by regfile write-through; the entry is kept for debug visibility.
    assign unused_wb = ^wb_q;

    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (!hold) begin
            ex_d  = (stall || !id_valid) ? '0 : {id_wen, id_is_load, id_waddr};
            mem_d = ex_q;
            wb_d  = mem_q;
            if (in_init) begin
                if (init_cnt_q <= IW'(1)) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q - IW'(1);
                end
            end else if (haz && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            state_q     <= ST_INIT;
            init_cnt_q  <= IW'(INIT_CYCLES);
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifdef PIPE_FWD_EN
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

    always_comb begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (!hold) begin
            if (stall || !id_valid) begin
                fwd_a_d = FWD_RF;
                fwd_b_d = FWD_RF;
            end else begin
                fwd_a_d = fwd_sel(rs1_ex_hit, rs1_mem_hit);
                fwd_b_d = fwd_sel(rs2_ex_hit, rs2_mem_hit);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;
`else
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios plus random traffic vs. a history model.
module tb_pipeline_hazard_ctrl;

    localparam int AW          = 5;
    localparam int CNT_W       = 16;
    localparam int INIT_CYCLES = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             hold = 1'b0;
    logic             id_valid = 1'b0;
    logic [AW-1:0]    id_rs1 = '0;
    logic [AW-1:0]    id_rs2 = '0;
    logic             id_rs1_used = 1'b0;
    logic             id_rs2_used = 1'b0;
    logic             id_wen = 1'b0;
    logic [AW-1:0]    id_waddr = '0;
    logic             id_is_load = 1'b0;
    logic             stall_pc, stall_ifid, bubble_idexe, busy_init;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .AW          (AW),
        .CNT_W       (CNT_W),
        .INIT_CYCLES (INIT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_wen       (id_wen),
        .id_waddr     (id_waddr),
        .id_is_load   (id_is_load),
        .stall_pc     (stall_pc),
        .stall_ifid   (stall_ifid),
        .bubble_idexe (bubble_idexe),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall_cnt    (stall_cnt),
        .busy_init    (busy_init)
    );

    int checks = 0;
    int errors = 0;

    // Model: record of what was issued 1 and 2 un-held cycles ago (older results live in the regfile).
    int         init_left;
    logic       h_wen   [1:2];
    logic [4:0] h_waddr [1:2];
    logic       h_load  [1:2];
    logic [1:0] m_fwd_a, m_fwd_b;
    int         m_cnt;

    task automatic model_reset();
        init_left = INIT_CYCLES;
        for (int d = 1; d <= 2; d++) begin
            h_wen[d] = 1'b0; h_waddr[d] = '0; h_load[d] = 1'b0;
        end
        m_fwd_a = 2'b00; m_fwd_b = 2'b00; m_cnt = 0;
    endtask

    // Distance back to the nearest in-flight producer of s (0 = none in flight).
    function automatic int producer_dist(input logic used, input logic [AW-1:0] s);
        for (int d = 1; d <= 2; d++)
            if (used && s != 0 && h_wen[d] && h_waddr[d] == s) return d;
        return 0;
    endfunction

    function automatic logic [1:0] sel_for(input int d);
`ifdef PIPE_FWD_EN
        if (d == 1) return 2'b01;
        if (d == 2) return 2'b10;
`endif
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_busy", 32'(busy_init), 32'd1);
        check("rst_stall_pc", 32'(stall_pc), 32'd1);
        check("rst_stall_ifid", 32'(stall_ifid), 32'd1);
        check("rst_bubble", 32'(bubble_idexe), 32'd1);
        check("rst_fwd_a", 32'(fwd_a), 32'd0);
        check("rst_fwd_b", 32'(fwd_b), 32'd0);
        check("rst_cnt", 32'(stall_cnt), 32'd0);
    endtask

    // One clock: drive ID, check at negedge against the model, advance the model, pass the edge.
    task automatic cycle(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic u1, input logic u2, input logic we,
                         input logic [AW-1:0] wa, input logic ld, input logic h,
                         output logic stalled);
        int  d1, d2;
        logic busy, haz, stl;
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rs1_used = u1; id_rs2_used = u2;
        id_wen = we; id_waddr = wa; id_is_load = ld; hold = h;
        @(negedge clk);
        d1   = producer_dist(u1, r1);
        d2   = producer_dist(u2, r2);
        busy = (init_left > 0);
`ifdef PIPE_FWD_EN
        haz = v && ((d1 == 1) || (d2 == 1)) && h_load[1];
`else
        haz = v && ((d1 != 0) || (d2 != 0));
`endif
        stl = busy || haz;
        check("busy_init", 32'(busy_init), 32'(busy));
        check("stall_pc", 32'(stall_pc), 32'(stl));
        check("stall_ifid", 32'(stall_ifid), 32'(stl));
        check("bubble_idexe", 32'(bubble_idexe), 32'(stl));
        check("fwd_a", 32'(fwd_a), 32'(m_fwd_a));
        check("fwd_b", 32'(fwd_b), 32'(m_fwd_b));
        check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        if (!h) begin
            h_wen[2] = h_wen[1]; h_waddr[2] = h_waddr[1]; h_load[2] = h_load[1];
            if (stl || !v) begin
                h_wen[1] = 1'b0; h_waddr[1] = '0; h_load[1] = 1'b0;
                m_fwd_a = 2'b00; m_fwd_b = 2'b00;
            end else begin
                h_wen[1] = we; h_waddr[1] = wa; h_load[1] = ld;
                m_fwd_a = sel_for(d1); m_fwd_b = sel_for(d2);
            end
            if (busy) init_left--;
            else if (haz && m_cnt < CNT_MAX) m_cnt++;
        end
        stalled = stl;
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int n);
        logic s;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, s);
    endtask

    initial begin
        logic s;
        int   tries;
        model_reset();
        #12;
        check_reset_state();
        @(posedge clk); #1;
        rst = 1'b1;

        // INIT window, then idle
        nop(INIT_CYCLES + 2);

        // add r3,r1,r2 ; add r4,r3,r5
        cycle(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0, s);
        tries = 0;
        do begin cycle(1, 5'd3, 5'd5, 1, 1, 1, 5'd4, 0, 0, s); tries++; end
        while (s && tries < 4);
        check("addadd_bound", 32'(s), 32'd0);
        nop(3);

        // lw r2 ; add r6,r2,r2
        cycle(1, 5'd1, 5'd0, 1, 0, 1, 5'd2, 1, 0, s);
        tries = 0;
        do begin cycle(1, 5'd2, 5'd2, 1, 1, 1, 5'd6, 0, 0, s); tries++; end
        while (s && tries < 4);
        check("loaduse_bound", 32'(s), 32'd0);
        nop(3);

        // write r0, read r0: never a hazard
        cycle(1, 5'd1, 5'd1, 1, 1, 1, 5'd0, 1, 0, s);
        cycle(1, 5'd0, 5'd0, 1, 1, 1, 5'd9, 0, 0, s);
        check("r0_no_stall", 32'(s), 32'd0);
        nop(2);

        // hold in the middle of a load-use stall
        cycle(1, 5'd1, 5'd0, 1, 0, 1, 5'd2, 1, 0, s);
        cycle(1, 5'd2, 5'd2, 1, 1, 1, 5'd6, 0, 1, s);
        cycle(1, 5'd2, 5'd2, 1, 1, 1, 5'd6, 0, 1, s);
        tries = 0;
        do begin cycle(1, 5'd2, 5'd2, 1, 1, 1, 5'd6, 0, 0, s); tries++; end
        while (s && tries < 4);
        check("hold_bound", 32'(s), 32'd0);
        nop(2);

        // asynchronous reset during a load-use stall
        cycle(1, 5'd1, 5'd0, 1, 0, 1, 5'd7, 1, 0, s);
        id_valid = 1; id_rs1 = 5'd7; id_rs2 = 5'd7; id_rs1_used = 1; id_rs2_used = 1;
        id_wen = 1; id_waddr = 5'd8; id_is_load = 0; hold = 0;
        #2;
        check("pre_rst_bubble", 32'(bubble_idexe), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_state();
        model_reset();
        @(posedge clk); #1;
        check_reset_state();
        rst = 1'b1;
        nop(INIT_CYCLES + 1);

        // random traffic over a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 7) != 0),
                  AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0), s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
